// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller, ALU and datapath.
// States, instruction fields, ALU op codes and mux select values.
package mc_pkg;

  localparam int OPW  = 6;
  localparam int ALUW = 3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_AND = 6'b100100;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;
  localparam logic [OPW-1:0] FN_SLT = 6'b101010;
  localparam logic [OPW-1:0] FN_SLL = 6'b000000;

  localparam logic [ALUW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUW-1:0] ALU_AND = 3'b010;
  localparam logic [ALUW-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUW-1:0] ALU_SLT = 3'b101;
  localparam logic [ALUW-1:0] ALU_SLL = 3'b110;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type funct decode: ALU op, operand-A select and a supported flag.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [OPW-1:0]  funct,
  output logic [ALUW-1:0] alu_op,
  output logic [1:0]      src_a,
  output logic            valid
);

  always_comb begin
    alu_op = ALU_ADD;
    src_a  = SRCA_REG;
    valid  = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_SLT: alu_op = ALU_SLT;
      FN_SLL: begin
        alu_op = ALU_SLL;
        src_a  = SRCA_SHAMT;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath control FSM: state register, next state, output decode.
// Outputs are decoded from the state register and forced low while rst is high.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  funct,
  input  logic            zero,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [ALUW-1:0] alu_op,
  output logic [1:0]      pc_src,
  output logic            pc_en
);

  state_t          state;
  logic            is_store;
  logic            is_slti;
  logic [ALUW-1:0] dec_alu_op;
  logic [1:0]      dec_src_a;
  logic            fn_valid;
  logic            pcwrite;
  logic            pcwritecond;

  alu_decoder u_alu_decoder (
    .funct  (funct),
    .alu_op (dec_alu_op),
    .src_a  (dec_src_a),
    .valid  (fn_valid)
  );

  // lw/sw and addi/slti are remembered at DECODE so opcode is not needed later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
      is_slti  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          is_store <= (opcode == OP_SW);
          is_slti  <= (opcode == OP_SLTI);
          case (opcode)
            OP_RTYPE:        state <= S_EXEC;
            OP_LW, OP_SW:    state <= S_MEMADR;
            OP_ADDI, OP_SLTI: state <= S_IEXEC;
            OP_BEQ:          state <= S_BRANCH;
            OP_J:            state <= S_JUMP;
            default:         state <= S_FETCH;
          endcase
        end
        S_MEMADR: state <= is_store ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state <= S_MEMWB;
        S_EXEC:   state <= fn_valid ? S_RWB : S_FETCH;
        S_IEXEC:  state <= S_IWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG;
    alu_op      = ALU_ADD;
    pc_src      = PC_ALU;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pcwrite   = 1'b1;
        end
        S_DECODE: alu_src_b = SRCB_BRANCH;
        S_MEMADR: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = dec_src_a;
          alu_op    = dec_alu_op;
        end
        S_RWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_IEXEC: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_IMM;
          alu_op    = is_slti ? ALU_SLT : ALU_ADD;
        end
        S_IWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = SRCA_REG;
          alu_op      = ALU_SUB;
          pc_src      = PC_ALUOUT;
          pcwritecond = 1'b1;
        end
        S_JUMP: begin
          pc_src  = PC_JUMP;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = pcwrite | (pcwritecond & zero);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle table plus random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic       pc_en;
  logic [16:0] act;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .pc_en(pc_en)
  );

  assign act = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, pc_en};

  function automatic logic [16:0] vec(input logic io, mr, mw, irw, rd, m2r, rw,
                                      input logic [1:0] sa, sb, input logic [2:0] op,
                                      input logic [1:0] ps, input logic pe);
    return {io, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps, pe};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic [16:0] exp;
    logic [16:0] care;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  task automatic add(input logic r, input logic [5:0] o, f, input logic z,
                     input logic [16:0] e, m, input string n);
    vec_t v;
    v.rst = r; v.opcode = o; v.funct = f; v.zero = z;
    v.exp = e; v.care = m; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input logic [16:0] e, m);
    tests++;
    if (((act ^ e) & m) != 17'd0) begin
      fails++;
      $display("FAIL %s: got %b expected %b (care %b)", n, act, e, m);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] o, f, input logic z);
    @(posedge clk);
    #1;
    rst = r; opcode = o; funct = f; zero = z;
    @(negedge clk);
  endtask

  // Reference model: cycle count and expected outputs per instruction step.
  function automatic int inst_len(input logic [5:0] op, fn);
    case (op)
      OP_LW:            return 5;
      OP_SW:            return 4;
      OP_ADDI, OP_SLTI: return 4;
      OP_BEQ, OP_J:     return 3;
      OP_RTYPE: begin
        if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR ||
            fn == FN_SLT || fn == FN_SLL) return 4;
        return 3;
      end
      default:          return 2;
    endcase
  endfunction

  task automatic model(input logic [5:0] op, fn, input logic z, input int k,
                       output logic [16:0] e, output logic [16:0] m);
    m = '1;
    e = '0;
    if (k == 0) e = vec(0,1,0,1,0,0,0, 2'b00, 2'b01, 3'b000, 2'b00, 1);
    else if (k == 1) e = vec(0,0,0,0,0,0,0, 2'b00, 2'b11, 3'b000, 2'b00, 0);
    else begin
      case (op)
        OP_LW, OP_SW: begin
          if (k == 2) e = vec(0,0,0,0,0,0,0, 2'b01, 2'b10, 3'b000, 2'b00, 0);
          else if (op == OP_SW) e = vec(1,0,1,0,0,0,0, 0, 0, 0, 0, 0);
          else if (k == 3) e = vec(1,1,0,0,0,0,0, 0, 0, 0, 0, 0);
          else e = vec(0,0,0,0,0,1,1, 0, 0, 0, 0, 0);
        end
        OP_ADDI, OP_SLTI: begin
          if (k == 2) e = vec(0,0,0,0,0,0,0, 2'b01, 2'b10,
                              (op == OP_SLTI) ? 3'b101 : 3'b000, 2'b00, 0);
          else e = vec(0,0,0,0,0,0,1, 0, 0, 0, 0, 0);
        end
        OP_BEQ: e = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b001, 2'b01, z);
        OP_J:   e = vec(0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 2'b10, 1);
        default: begin
          if (k == 3) e = vec(0,0,0,0,1,0,1, 0, 0, 0, 0, 0);
          else begin
            case (fn)
              FN_ADD: e = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 2'b00, 0);
              FN_SUB: e = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b001, 2'b00, 0);
              FN_AND: e = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 2'b00, 0);
              FN_OR:  e = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b011, 2'b00, 0);
              FN_SLT: e = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b101, 2'b00, 0);
              FN_SLL: e = vec(0,0,0,0,0,0,0, 2'b10, 2'b00, 3'b110, 2'b00, 0);
              default: m = vec(0,0,1,1,0,0,1, 0, 0, 0, 0, 1);
            endcase
          end
        end
      endcase
    end
  endtask

  initial begin
    logic [16:0] all_m, we_m, zv, f_v, d_v, ma_v, mr_v, mwb_v, mwr_v, rwb_v, iwb_v;
    logic [16:0] br1_v, br0_v, jmp_v, sub_v, sll_v, slt_v, e, m;
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    int len;

    all_m = '1;
    we_m  = vec(0,0,1,1,0,0,1, 0, 0, 0, 0, 1);
    zv    = '0;
    f_v   = vec(0,1,0,1,0,0,0, 2'b00, 2'b01, 3'b000, 2'b00, 1);
    d_v   = vec(0,0,0,0,0,0,0, 2'b00, 2'b11, 3'b000, 2'b00, 0);
    ma_v  = vec(0,0,0,0,0,0,0, 2'b01, 2'b10, 3'b000, 2'b00, 0);
    mr_v  = vec(1,1,0,0,0,0,0, 0, 0, 0, 0, 0);
    mwb_v = vec(0,0,0,0,0,1,1, 0, 0, 0, 0, 0);
    mwr_v = vec(1,0,1,0,0,0,0, 0, 0, 0, 0, 0);
    rwb_v = vec(0,0,0,0,1,0,1, 0, 0, 0, 0, 0);
    iwb_v = vec(0,0,0,0,0,0,1, 0, 0, 0, 0, 0);
    br1_v = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b001, 2'b01, 1);
    br0_v = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b001, 2'b01, 0);
    jmp_v = vec(0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 2'b10, 1);
    sub_v = vec(0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b001, 2'b00, 0);
    sll_v = vec(0,0,0,0,0,0,0, 2'b10, 2'b00, 3'b110, 2'b00, 0);
    slt_v = vec(0,0,0,0,0,0,0, 2'b01, 2'b10, 3'b101, 2'b00, 0);

    add(1, 6'h3f, 6'h3f, 1, zv, all_m, "reset_0");
    add(1, 0, 0, 1, zv, all_m, "reset_1");
    add(0, OP_J, 0, 0, f_v, all_m, "lw_fetch");
    add(0, OP_LW, 0, 0, d_v, all_m, "lw_decode");
    add(0, OP_SW, 0, 0, ma_v, all_m, "lw_memadr");
    add(0, 0, 0, 0, mr_v, all_m, "lw_memrd");
    add(0, 0, 0, 0, mwb_v, all_m, "lw_memwb");
    add(0, 0, 0, 0, f_v, all_m, "beq1_fetch");
    add(0, OP_BEQ, 0, 0, d_v, all_m, "beq1_decode");
    add(0, 0, 0, 1, br1_v, all_m, "beq_taken");
    add(0, 0, 0, 0, f_v, all_m, "beq0_fetch");
    add(0, OP_BEQ, 0, 1, d_v, all_m, "beq0_decode");
    add(0, 0, 0, 0, br0_v, all_m, "beq_not_taken");
    add(0, 0, 0, 0, f_v, all_m, "sub_fetch");
    add(0, OP_RTYPE, 0, 0, d_v, all_m, "sub_decode");
    add(0, OP_LW, FN_SUB, 0, sub_v, all_m, "sub_exec");
    add(0, 0, 6'h3f, 0, rwb_v, all_m, "sub_rwb");
    add(0, 0, 0, 0, f_v, all_m, "sll_fetch");
    add(0, OP_RTYPE, 0, 0, d_v, all_m, "sll_decode");
    add(0, 0, FN_SLL, 0, sll_v, all_m, "sll_exec");
    add(0, 0, 0, 0, rwb_v, all_m, "sll_rwb");
    add(0, 0, 0, 0, f_v, all_m, "slti_fetch");
    add(0, OP_SLTI, 0, 0, d_v, all_m, "slti_decode");
    add(0, OP_ADDI, 0, 0, slt_v, all_m, "slti_iexec");
    add(0, 0, 0, 0, iwb_v, all_m, "slti_iwb");
    add(0, 0, 0, 0, f_v, all_m, "nop_fetch");
    add(0, 6'h3f, 0, 0, d_v, all_m, "nop_decode");
    add(0, 0, 0, 0, f_v, all_m, "badfn_fetch");
    add(0, OP_RTYPE, 0, 0, d_v, all_m, "badfn_decode");
    add(0, 0, 6'h3f, 0, zv, we_m, "badfn_exec");
    add(0, 0, 0, 0, f_v, all_m, "rstlw_fetch");
    add(0, OP_LW, 0, 0, d_v, all_m, "rstlw_decode");
    add(0, 0, 0, 0, ma_v, all_m, "rstlw_memadr");
    add(1, 0, 0, 1, zv, all_m, "rstlw_rst_memrd");
    add(1, 0, 0, 1, zv, all_m, "rstlw_rst_hold");
    add(0, 0, 0, 0, f_v, all_m, "sw_fetch");
    add(0, OP_SW, 0, 0, d_v, all_m, "sw_decode");
    add(0, OP_LW, 0, 0, ma_v, all_m, "sw_memadr");
    add(0, 0, 0, 0, mwr_v, all_m, "sw_memwr");
    add(0, 0, 0, 0, f_v, all_m, "j_fetch");
    add(0, OP_J, 0, 0, d_v, all_m, "j_decode");
    add(0, 0, 0, 0, jmp_v, all_m, "j_jump");

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].opcode, tbl[i].funct, tbl[i].zero);
      check(tbl[i].name, tbl[i].exp, tbl[i].care);
    end

    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL};
    repeat (300) begin
      case ($urandom_range(0, 7))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_ADDI;
        4: op = OP_SLTI;
        5: op = OP_BEQ;
        6: op = OP_J;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 5)];
      len = inst_len(op, fn);
      for (int k = 0; k < len; k++) begin
        logic [5:0] o, f;
        logic z;
        o = (k == 1) ? op : 6'($urandom);
        f = (k == 2) ? fn : 6'($urandom);
        z = 1'($urandom);
        cyc(0, o, f, z);
        model(op, fn, z, k, e, m);
        check($sformatf("rand_op%b_fn%b_k%0d", op, fn, k), e, m);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
